// File: rtl/rf_fill_check.sv
// rf_fill_check: fills every rf register with (i*i)^pattern through the write port,
// then reads them back two per cycle and reports the mismatch count and the first failing index.
module rf_fill_check #(
   parameter int NREGS    = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   output logic [ADDR_W-1:0] wn,
   output logic [DATA_W-1:0] wd,
   output logic              w,
   output logic [ADDR_W-1:0] rs1,
   output logic [ADDR_W-1:0] rs2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_idx
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   localparam logic [ADDR_W:0] last_w = (ADDR_W+1)'(NREGS - 1);
   localparam logic [ADDR_W:0] last_r = (ADDR_W+1)'(NREGS - 2);

   state_t            state, state_n;
   logic [ADDR_W:0]   idx, idx1, ecnt;
   logic [DATA_W-1:0] pattern_q;
   logic              m1, m2;

   function automatic logic [DATA_W-1:0] sq(input logic [ADDR_W:0] i);
      logic [DATA_W-1:0] v;
      v = DATA_W'(i);
      return v * v;
   endfunction

   // register 0 is written like the others; only its expected read-back changes
   function automatic logic [DATA_W-1:0] expv(input logic [ADDR_W:0] i, input logic [DATA_W-1:0] p);
      return (ZERO_REG != 0 && i == '0) ? '0 : sq(i) ^ p;
   endfunction

   assign idx1 = idx + (ADDR_W+1)'(1);
   assign m1   = (state == READ) && (rd1 != expv(idx, pattern_q));
   assign m2   = (state == READ) && (rd2 != expv(idx1, pattern_q));
   assign ecnt = {{ADDR_W{1'b0}}, m1} + {{ADDR_W{1'b0}}, m2};

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      w       = 1'b0;
      wn      = '0;
      wd      = '0;
      rs1     = '0;
      rs2     = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE:  state_n = start ? WRITE : IDLE;
         WRITE: begin
            w       = 1'b1;
            busy    = 1'b1;
            wn      = idx[ADDR_W-1:0];
            wd      = sq(idx) ^ pattern_q;
            state_n = (idx == last_w) ? READ : WRITE;
         end
         READ: begin
            busy    = 1'b1;
            rs1     = idx[ADDR_W-1:0];
            rs2     = idx1[ADDR_W-1:0];
            state_n = (idx == last_r) ? DONE : READ;
         end
         default: begin
            done    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx           <= '0;
         pattern_q     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (state == IDLE && start) begin
         idx           <= '0;
         pattern_q     <= pattern;
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (state == WRITE) begin
         idx <= (idx == last_w) ? '0 : idx1;
      end else if (state == READ) begin
         idx       <= idx + (ADDR_W+1)'(2);
         err_count <= err_count + ecnt;
         if (err_count == '0 && (m1 || m2))
            first_err_idx <= m1 ? idx[ADDR_W-1:0] : idx1[ADDR_W-1:0];
      end
   end
endmodule

// File: doc/rf_fill_check.md
Name: rf_fill_check

Overview:
- Sequencer that drives the write and read ports of the team's register file (`rf`) from the controller side.
- On `start` it fills every register with a deterministic pattern through the single write port.
- It then reads all registers back through the two read ports, one pair per cycle, and compares against the expected pattern.
- Used as the power-on initialiser and built-in self-check for `rf`; reports mismatch count, first failing index and completion.

Parameters:
- NREGS, 32, number of registers filled and checked; even, power of two.
- ADDR_W, 5, register index width; log2(NREGS).
- DATA_W, 32, register data width.
- ZERO_REG, 1, when 1 register 0 is hardwired: expected read value of index 0 is 0 regardless of pattern.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a fill/check run; sampled in IDLE only.
- pattern  in  DATA_W  XOR mask, captured when start is accepted.
- wn  out  ADDR_W  rf write register number.
- wd  out  DATA_W  rf write data.
- w  out  1  rf write enable.
- rs1  out  ADDR_W  rf read address 1.
- rs2  out  ADDR_W  rf read address 2.
- rd1  in  DATA_W  rf read data 1; combinational from rs1.
- rd2  in  DATA_W  rf read data 2; combinational from rs2.
- busy  out  1  high during WRITE and READ.
- done  out  1  one-cycle pulse at end of run.
- err_count  out  ADDR_W+1  number of mismatching registers in the last run.
- first_err_idx  out  ADDR_W  index of the lowest-numbered mismatching register; 0 if none.

Behaviour:
- Reset (synchronous):
  - Sets state IDLE, idx 0, captured pattern 0.
  - Outputs: w=0, wn=0, wd=0, rs1=0, rs2=0, busy=0, done=0, err_count=0, first_err_idx=0.
  - Reset mid-run aborts immediately: w=0 from the cycle after the reset edge; no further writes.
- Expected value: E(i) = ((i*i) mod 2^DATA_W) XOR pattern_q. If ZERO_REG=1, E(0)=0.
- IDLE:
  - w=0, busy=0.
  - start=1 captures pattern, clears err_count and first_err_idx, sets idx=0, and moves to WRITE.
- WRITE (NREGS cycles):
  - Drives w=1, wn=idx, wd=((idx*idx) mod 2^DATA_W) XOR pattern_q.
  - The rf commits on the same rising edge; idx increments.
  - After idx=NREGS-1: idx=0, state moves to READ.
  - Register 0 is written like any other register; ZERO_REG only affects the comparison.
- READ (NREGS/2 cycles):
  - w=0, rs1=idx, rs2=idx+1.
  - rd1/rd2 are compared against E(idx) and E(idx+1) at the same rising edge.
  - Each mismatch increments err_count; two mismatches in one cycle add 2.
  - first_err_idx is updated only while err_count==0 before that edge; if both mismatch, the lower index (idx) wins.
  - idx += 2. After the pair (NREGS-2, NREGS-1): state moves to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
  - err_count and first_err_idx hold until the next accepted start or reset.
- start while busy or in DONE is ignored; it is not queued.
- reset has priority over start on the same edge.
- Latency: start accepted at edge 0; writes occupy cycles 1..NREGS; reads occupy the next NREGS/2 cycles; done is high in cycle 3*NREGS/2+1 (49 for defaults).
- idx never wraps mid-state; the counter is ADDR_W+1 bits wide internally so the terminal test is exact.

Test Plan:
- Clean run: real rf, pattern=0, start pulse -> 32 writes with wd=i*i (wn=31 carries wd=961), done in cycle 49, err_count=0, first_err_idx=0.
- Pattern and zero register: ZERO_REG=1, pattern=32'hFFFF0000, rf with x0 hardwired -> reg 5 written as 32'hFFFF0019; no mismatch at index 0; err_count=0.
- Fault injection: bench forces rd2 to 0 whenever rs2=7 -> err_count=1, first_err_idx=7. Forcing both rd1 and rd2 wrong for rs1=10/rs2=11 -> err_count=2, first_err_idx=10.
- Reset mid-WRITE: assert reset while wn=10 -> w=0 and busy=0 the following cycle, err_count=0, no done pulse. A new start then completes normally in 49 cycles.
- Start while busy: extra start pulses during the WRITE and READ phases -> ignored; exactly one done pulse at cycle 49.
- Back-to-back runs: start in the cycle after the DONE cycle -> accepted; err_count clears in the same cycle as acceptance.
